// File: rtl/acc_pkg.sv
//------------------------------------------------------------------------------
// Module   : acc_pkg
// Brief    : Op encoding and FSM state enums shared by the accumulator unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package acc_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_LOAD_BUS = 3'd1,
    OP_LOAD_ALU = 3'd2,
    OP_INC      = 3'd3,
    OP_DEC      = 3'd4,
    OP_CLR      = 3'd5,
    OP_SHL      = 3'd6,
    OP_SHR      = 3'd7
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : acc_pkg

`default_nettype wire

// File: rtl/acc_unit.sv
//------------------------------------------------------------------------------
// Module   : acc_unit
// Brief    : Accumulator with R register, inc/dec/clear and multi-cycle shifts.
//            Optional macro ACC_SAT_EN makes INC/DEC saturate instead of wrap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acc_unit
  import acc_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  bus_in,
  input  logic [DATA_W-1:0]  alu_in,
  input  logic [2:0]         op,
  input  logic               op_valid,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               cap_r,
  output logic               op_ready,
  output logic [DATA_W-1:0]  acc_out,
  output logic [DATA_W-1:0]  r_out,
  output logic               zero,
  output logic               carry,
  output logic               busy
);

  localparam logic [SHAMT_W-1:0] c_CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W:0]    c_ONE_EXT = {{DATA_W{1'b0}}, 1'b1};

  state_e              r_state;
  state_e              w_state_nxt;
  logic [SHAMT_W-1:0]  r_cnt;
  logic [SHAMT_W-1:0]  w_cnt_nxt;
  logic                r_left;
  logic                w_left_nxt;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   w_acc_nxt;
  logic                r_carry;
  logic                w_carry_nxt;
  logic [DATA_W-1:0]   r_r;
  op_e                 w_op;
  logic [DATA_W:0]     w_inc_full;
  logic [DATA_W:0]     w_dec_full;

  assign w_op       = op_e'(op);
  // Top bit is carry-out for the increment and borrow for the decrement.
  assign w_inc_full = {1'b0, r_acc} + c_ONE_EXT;
  assign w_dec_full = {1'b0, r_acc} - c_ONE_EXT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_left_nxt  = r_left;
    w_acc_nxt   = r_acc;
    w_carry_nxt = r_carry;
    case (r_state)
      ST_IDLE: begin
        if (op_valid) begin
          case (w_op)
            OP_NOP:      ;
            OP_LOAD_BUS: w_acc_nxt = bus_in;
            OP_LOAD_ALU: w_acc_nxt = alu_in;
            OP_INC: begin
`ifdef ACC_SAT_EN
              if (&r_acc) begin
                w_carry_nxt = 1'b1;
              end else begin
                {w_carry_nxt, w_acc_nxt} = w_inc_full;
              end
`else
              {w_carry_nxt, w_acc_nxt} = w_inc_full;
`endif
            end
            OP_DEC: begin
`ifdef ACC_SAT_EN
              if (r_acc == '0) begin
                w_carry_nxt = 1'b1;
              end else begin
                {w_carry_nxt, w_acc_nxt} = w_dec_full;
              end
`else
              {w_carry_nxt, w_acc_nxt} = w_dec_full;
`endif
            end
            OP_CLR: begin
              w_acc_nxt   = '0;
              w_carry_nxt = 1'b0;
            end
            OP_SHL, OP_SHR: begin
              // A zero shift amount never leaves IDLE, so it acts as a NOP.
              if (shamt != '0) begin
                w_state_nxt = ST_SHIFT;
                w_cnt_nxt   = shamt;
                w_left_nxt  = (w_op == OP_SHL);
              end
            end
            default: ;
          endcase
        end
      end
      ST_SHIFT: begin
        if (r_left) begin
          w_acc_nxt   = {r_acc[DATA_W-2:0], 1'b0};
          w_carry_nxt = r_acc[DATA_W-1];
        end else begin
          w_acc_nxt   = {1'b0, r_acc[DATA_W-1:1]};
          w_carry_nxt = r_acc[0];
        end
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_r     <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_left  <= w_left_nxt;
      r_acc   <= w_acc_nxt;
      r_carry <= w_carry_nxt;
      if (cap_r) begin
        r_r <= bus_in;
      end
    end
  end

  assign op_ready = (r_state == ST_IDLE);
  assign busy     = ~op_ready;
  assign acc_out  = r_acc;
  assign r_out    = r_r;
  assign carry    = r_carry;
  assign zero     = (r_acc == '0);

endmodule : acc_unit

`default_nettype wire

// File: doc/acc_unit.md
ACC_UNIT -- requirements
Module: acc_unit

Interface
REQ-001 Parameter DATA_W, default 12: accumulator, R-register and bus data width.
REQ-002 Parameter SHAMT_W, default 4: shift-amount field width; max shift is 2^SHAMT_W-1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 bus_in  input  DATA_W  data from bus; source for LOAD_BUS and R capture.
REQ-006 alu_in  input  DATA_W  ALU result; source for LOAD_ALU.
REQ-007 op  input  3  command: 0 NOP, 1 LOAD_BUS, 2 LOAD_ALU, 3 INC, 4 DEC, 5 CLR, 6 SHL, 7 SHR.
REQ-008 op_valid  input  1  op is valid this cycle.
REQ-009 shamt  input  SHAMT_W  shift count, sampled with SHL/SHR.
REQ-010 cap_r  input  1  capture bus_in into r_out.
REQ-011 op_ready  output  1  unit accepts an op this cycle.
REQ-012 acc_out  output  DATA_W  accumulator value, driven to bus.
REQ-013 r_out  output  DATA_W  R-register value.
REQ-014 zero  output  1  acc_out == 0.
REQ-015 carry  output  1  carry/borrow/shift-out flag.
REQ-016 busy  output  1  multi-cycle shift in progress; always equals ~op_ready.

Function
REQ-017 An op SHALL be accepted only on a cycle with op_valid && op_ready; ops offered while op_ready is low are ignored, not queued.
REQ-018 FSM states SHALL be IDLE and SHIFT; op_ready = (state == IDLE).
REQ-019 LOAD_BUS/LOAD_ALU SHALL load acc_out at the accepting edge (1-cycle latency), carry unchanged.
REQ-020 INC SHALL set acc_out = acc_out+1 modulo 2^DATA_W, carry = carry-out; DEC SHALL set acc_out-1 modulo 2^DATA_W, carry = borrow.
REQ-021 CLR SHALL set acc_out = 0 and carry = 0.
REQ-022 NOP SHALL change nothing.
REQ-023 SHL/SHR with shamt = k > 0 SHALL enter SHIFT with counter = k, shift acc_out one bit per cycle (zero fill), carry = bit shifted out, decrement the counter, and return to IDLE after the k-th shift; op_ready is low for exactly k cycles after acceptance.
REQ-024 SHL/SHR with shamt = 0 SHALL behave as NOP and stay in IDLE.
REQ-025 Shift amounts >= DATA_W SHALL run the full k cycles; acc_out ends at 0.
REQ-026 cap_r SHALL load r_out from bus_in at the next edge in any state, independent of op and concurrent with it.
REQ-027 zero SHALL be derived combinationally from the acc_out register.

Reset
REQ-028 rst_n low SHALL immediately force acc_out = 0, r_out = 0, carry = 0, state = IDLE, and counter = 0; zero reads 1 and op_ready reads 1 during and after reset.
REQ-029 Reset asserted mid-shift SHALL abort the shift with no partial result retained.

Configuration
REQ-030 With macro ACC_SAT_EN defined, INC at all-ones SHALL hold all-ones and DEC at 0 SHALL hold 0, each setting carry = 1; other ops are unaffected.
REQ-031 Without ACC_SAT_EN, INC and DEC SHALL wrap as in REQ-020.

Structure
REQ-032 Shared package acc_pkg SHALL hold the op encoding enum and the FSM state enum.
REQ-033 The block SHALL be a single module with no sub-module; the shift counter and datapath stay inline.

Verification (DATA_W=12)
REQ-034 Reset release, then LOAD_BUS 0x0A5 -> acc_out = 0x0A5 one edge later, zero = 0, op_ready stays 1.
REQ-035 acc = 0xFFF, INC -> acc = 0x000, carry = 1, zero = 1; with ACC_SAT_EN -> acc = 0xFFF, carry = 1.
REQ-036 acc = 0x001, SHL shamt = 3 -> op_ready low 3 cycles, acc = 0x008, carry = 0; a LOAD_ALU offered mid-shift is ignored.
REQ-037 acc = 0x003, SHR shamt = 1 -> acc = 0x001, carry = 1 after 1 cycle; SHR shamt = 0 -> no change, op_ready stays 1.
REQ-038 cap_r with bus_in = 0x123 during a shift -> r_out = 0x123 next edge, shift completes unaffected.
REQ-039 rst_n pulsed low in the 2nd cycle of SHL shamt = 5 -> acc = 0, carry = 0, op_ready = 1 immediately.
